// File: rtl/decode_stage_pipe.sv
// Decode stage with register file (write-first bypass), load-use hazard stall,
// bubble/flush insertion and the D/E pipeline register feeding execute.
module decode_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CTRLW = 16,
  parameter int CNTW  = 16,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_D,
  input  logic              valid_D,
  input  logic [CTRLW-1:0]  ctrl_D,
  input  logic [XLEN-1:0]   imm_D,
  input  logic [XLEN-1:0]   pc_D,
  input  logic              uses_rs1_D,
  input  logic              uses_rs2_D,
  input  logic              isLoad_D,
  input  logic              flush_E,
  input  logic              regWrite_W,
  input  logic [AW-1:0]     Rd_W,
  input  logic [XLEN-1:0]   result_W,
  output logic              stall_D,
  output logic              valid_E,
  output logic              isLoad_E,
  output logic [CTRLW-1:0]  ctrl_E,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [XLEN-1:0]   imm_E,
  output logic [XLEN-1:0]   pc_E,
  output logic [AW-1:0]     Rs1_E,
  output logic [AW-1:0]     Rs2_E,
  output logic [AW-1:0]     Rd_E,
  output logic [XLEN-1:0]   a0,
  output logic [CNTW-1:0]   stall_cnt
);

  localparam logic [AW-1:0]   A0_IDX  = AW'(10);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   rs1, rs2, rd;
  logic            wr_en;
  logic [XLEN-1:0] rd1, rd2;
  logic            bubble;
  logic            unused_instr;

  // Fields outside rs1/rs2/rd belong to the external decoder.
  assign unused_instr = ^instr_D;

  assign rs1   = AW'(instr_D[19:15]);
  assign rs2   = AW'(instr_D[24:20]);
  assign rd    = AW'(instr_D[11:7]);
  assign wr_en = regWrite_W && (Rd_W != '0);

  assign rd1 = (wr_en && (Rd_W == rs1)) ? result_W : regs[rs1];
  assign rd2 = (wr_en && (Rd_W == rs2)) ? result_W : regs[rs2];
  assign a0  = regs[A0_IDX];

  assign stall_D = valid_D && valid_E && isLoad_E && (Rd_E != '0) &&
                   ((uses_rs1_D && (rs1 == Rd_E)) || (uses_rs2_D && (rs2 == Rd_E)));
  assign bubble  = flush_E || stall_D;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[Rd_W] <= result_W;
    end
  end

  // D -> E stage boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_E  <= 1'b0;
      isLoad_E <= 1'b0;
      ctrl_E   <= '0;
      RD1_E    <= '0;
      RD2_E    <= '0;
      imm_E    <= '0;
      pc_E     <= '0;
      Rs1_E    <= '0;
      Rs2_E    <= '0;
      Rd_E     <= '0;
    end else if (bubble) begin
      valid_E  <= 1'b0;
      isLoad_E <= 1'b0;
      ctrl_E   <= '0;
      RD1_E    <= '0;
      RD2_E    <= '0;
      imm_E    <= '0;
      pc_E     <= '0;
      Rs1_E    <= '0;
      Rs2_E    <= '0;
      Rd_E     <= '0;
    end else begin
      valid_E  <= valid_D;
      isLoad_E <= valid_D && isLoad_D;
      ctrl_E   <= valid_D ? ctrl_D : '0;
      RD1_E    <= rd1;
      RD2_E    <= rd2;
      imm_E    <= imm_D;
      pc_E     <= pc_D;
      Rs1_E    <= rs1;
      Rs2_E    <= rs2;
      Rd_E     <= rd;
    end
  end

  // A stall overridden by a flush is not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_D && !flush_E && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed vector table, random run against a
// behavioural model, and hand sequences for counter saturation and async reset.
module tb_decode_stage_pipe;

  localparam int XLEN = 32, NREGS = 32, CTRLW = 16, CNTW = 2, AW = 5;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] instr_D = '0;
  logic valid_D = 0, uses_rs1_D = 0, uses_rs2_D = 0, isLoad_D = 0, flush_E = 0, regWrite_W = 0;
  logic [CTRLW-1:0] ctrl_D = '0;
  logic [XLEN-1:0] imm_D = '0, pc_D = '0, result_W = '0;
  logic [AW-1:0] Rd_W = '0;
  logic stall_D, valid_E, isLoad_E;
  logic [CTRLW-1:0] ctrl_E;
  logic [XLEN-1:0] RD1_E, RD2_E, imm_E, pc_E, a0;
  logic [AW-1:0] Rs1_E, Rs2_E, Rd_E;
  logic [CNTW-1:0] stall_cnt;

  int tests = 0, fails = 0;
  logic stall_s;

  decode_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS), .CTRLW(CTRLW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .instr_D(instr_D), .valid_D(valid_D), .ctrl_D(ctrl_D),
    .imm_D(imm_D), .pc_D(pc_D), .uses_rs1_D(uses_rs1_D), .uses_rs2_D(uses_rs2_D),
    .isLoad_D(isLoad_D), .flush_E(flush_E), .regWrite_W(regWrite_W), .Rd_W(Rd_W),
    .result_W(result_W), .stall_D(stall_D), .valid_E(valid_E), .isLoad_E(isLoad_E),
    .ctrl_E(ctrl_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .imm_E(imm_E), .pc_E(pc_E),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E), .a0(a0), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr; logic vd; logic [15:0] ctrl;
    logic u1, u2, ld, fl, rw; logic [4:0] rdw; logic [31:0] res;
    logic e_stall, e_vld, e_ld; logic [15:0] e_ctrl; logic [31:0] e_rd1, e_rd2;
    logic [4:0] e_rd; logic [1:0] e_cnt; logic [31:0] e_a0; logic e_bub;
  } vec_t;

  typedef struct {
    logic vld, ld; logic [15:0] ctrl; logic [31:0] rd1, rd2, imm, pc;
    logic [4:0] rs1, rs2, rd;
  } estate_t;

  function automatic logic [31:0] mk(input int rd, input int r1, input int r2);
    logic [4:0] a, b, c;
    a = rd[4:0]; b = r1[4:0]; c = r2[4:0];
    return {7'b0, c, b, 3'b0, a, 7'h33};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic vd, input logic [15:0] ctrl,
                       input logic u1, input logic u2, input logic ld, input logic fl,
                       input logic rw, input logic [4:0] rdw, input logic [31:0] res,
                       input logic [31:0] imm, input logic [31:0] pc);
    instr_D = ins; valid_D = vd; ctrl_D = ctrl; uses_rs1_D = u1; uses_rs2_D = u2;
    isLoad_D = ld; flush_E = fl; regWrite_W = rw; Rd_W = rdw; result_W = res;
    imm_D = imm; pc_D = pc;
  endtask

  // One cycle: drive at negedge, sample stall before the edge, then settle after it.
  task automatic cyc(input logic [31:0] ins, input logic vd, input logic [15:0] ctrl,
                     input logic u1, input logic u2, input logic ld, input logic fl,
                     input logic rw, input logic [4:0] rdw, input logic [31:0] res);
    @(negedge clk);
    drive(ins, vd, ctrl, u1, u2, ld, fl, rw, rdw, res, 32'h0, 32'h0);
    #1 stall_s = stall_D;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive('0, 0, '0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  vec_t tbl[15];
  logic [31:0] mregs[NREGS];
  estate_t e, en;
  int mcnt;

  function automatic logic [31:0] mread(input logic [4:0] idx, input logic rw,
                                        input logic [4:0] rdw, input logic [31:0] res);
    if (rw && rdw != 0 && rdw == idx) return res;
    return mregs[idx];
  endfunction

  initial begin
    tbl[0]  = '{mk(3,1,2),  1, 16'h0005, 1,1,0,0, 0, 0, 32'h0,          0,1,0,16'h0005, 32'h0,        32'h0, 3, 0, 32'h0,        0};
    tbl[1]  = '{mk(4,5,0),  1, 16'h0001, 1,0,0,0, 1, 5, 32'hDEADBEEF,   0,1,0,16'h0001, 32'hDEADBEEF, 32'h0, 4, 0, 32'h0,        0};
    tbl[2]  = '{mk(7,5,0),  1, 16'h0002, 1,0,1,0, 0, 0, 32'h0,          0,1,1,16'h0002, 32'hDEADBEEF, 32'h0, 7, 0, 32'h0,        0};
    tbl[3]  = '{mk(8,1,7),  1, 16'h0003, 1,1,0,0, 0, 0, 32'h0,          1,0,0,16'h0000, 32'h0,        32'h0, 0, 1, 32'h0,        1};
    tbl[4]  = '{mk(8,1,7),  1, 16'h0003, 1,1,0,0, 0, 0, 32'h0,          0,1,0,16'h0003, 32'h0,        32'h0, 8, 1, 32'h0,        0};
    tbl[5]  = '{mk(0,0,0),  1, 16'h0004, 0,0,1,0, 0, 0, 32'h0,          0,1,1,16'h0004, 32'h0,        32'h0, 0, 1, 32'h0,        0};
    tbl[6]  = '{mk(9,0,0),  1, 16'h0006, 1,1,0,0, 0, 0, 32'h0,          0,1,0,16'h0006, 32'h0,        32'h0, 9, 1, 32'h0,        0};
    tbl[7]  = '{mk(7,0,0),  1, 16'h0007, 0,0,1,0, 0, 0, 32'h0,          0,1,1,16'h0007, 32'h0,        32'h0, 7, 1, 32'h0,        0};
    tbl[8]  = '{mk(11,7,0), 1, 16'h0008, 0,1,0,0, 0, 0, 32'h0,          0,1,0,16'h0008, 32'h0,        32'h0, 11,1, 32'h0,        0};
    tbl[9]  = '{mk(7,0,0),  1, 16'h0009, 0,0,1,0, 0, 0, 32'h0,          0,1,1,16'h0009, 32'h0,        32'h0, 7, 1, 32'h0,        0};
    tbl[10] = '{mk(12,7,0), 1, 16'h000A, 1,0,0,1, 0, 0, 32'h0,          1,0,0,16'h0000, 32'h0,        32'h0, 0, 1, 32'h0,        1};
    tbl[11] = '{mk(13,5,5), 1, 16'h000B, 1,1,0,1, 0, 0, 32'h0,          0,0,0,16'h0000, 32'h0,        32'h0, 0, 1, 32'h0,        1};
    tbl[12] = '{mk(14,10,0),1, 16'h000C, 1,0,0,0, 1, 10,32'h12345678,   0,1,0,16'h000C, 32'h12345678, 32'h0, 14,1, 32'h12345678, 0};
    tbl[13] = '{mk(1,0,0),  1, 16'h000D, 1,0,0,0, 1, 0, 32'hFFFFFFFF,   0,1,0,16'h000D, 32'h0,        32'h0, 1, 1, 32'h12345678, 0};
    tbl[14] = '{mk(15,10,0),0, 16'hFFFF, 1,0,1,0, 0, 0, 32'h0,          0,0,0,16'h0000, 32'h12345678, 32'h0, 15,1, 32'h12345678, 0};

    // Reset state while rst is held low
    #3;
    chk("rst valid_E", valid_E, 0);   chk("rst ctrl_E", ctrl_E, 0);
    chk("rst RD1_E", RD1_E, 0);       chk("rst a0", a0, 0);
    chk("rst stall_cnt", stall_cnt, 0); chk("rst stall_D", stall_D, 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].instr, tbl[i].vd, tbl[i].ctrl, tbl[i].u1, tbl[i].u2, tbl[i].ld, tbl[i].fl,
            tbl[i].rw, tbl[i].rdw, tbl[i].res, 32'hA0000000 + i, 32'h1000 + 4 * i);
      #1 chk($sformatf("vec%0d stall_D", i), stall_D, tbl[i].e_stall);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d valid_E", i), valid_E, tbl[i].e_vld);
      chk($sformatf("vec%0d isLoad_E", i), isLoad_E, tbl[i].e_ld);
      chk($sformatf("vec%0d ctrl_E", i), ctrl_E, tbl[i].e_ctrl);
      chk($sformatf("vec%0d RD1_E", i), RD1_E, tbl[i].e_rd1);
      chk($sformatf("vec%0d RD2_E", i), RD2_E, tbl[i].e_rd2);
      chk($sformatf("vec%0d Rd_E", i), Rd_E, tbl[i].e_rd);
      chk($sformatf("vec%0d stall_cnt", i), stall_cnt, tbl[i].e_cnt);
      chk($sformatf("vec%0d a0", i), a0, tbl[i].e_a0);
      chk($sformatf("vec%0d imm_E", i), imm_E, tbl[i].e_bub ? 32'h0 : 32'hA0000000 + i);
      chk($sformatf("vec%0d pc_E", i), pc_E, tbl[i].e_bub ? 32'h0 : 32'h1000 + 4 * i);
    end

    // Random run against the model
    do_reset();
    for (int i = 0; i < NREGS; i++) mregs[i] = '0;
    e = '{default: '0};
    mcnt = 0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins, res, imm, pc;
      logic [4:0] r1, r2, rdd, rdw;
      logic vd, u1, u2, ld, fl, rw, haz;
      logic [15:0] ctrl;
      ins = $urandom; r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
      rdd = 5'($urandom_range(0, 7)); rdw = 5'($urandom_range(0, 11));
      ins[19:15] = r1; ins[24:20] = r2; ins[11:7] = rdd;
      vd = ($urandom % 8) != 0; u1 = $urandom % 2 == 0; u2 = $urandom % 2 == 0;
      ld = ($urandom % 3) == 0; fl = ($urandom % 10) == 0; rw = $urandom % 2 == 0;
      res = $urandom; imm = $urandom; pc = $urandom; ctrl = 16'($urandom);
      haz = vd && e.vld && e.ld && e.rd != 0 && ((u1 && r1 == e.rd) || (u2 && r2 == e.rd));
      if (fl || haz) en = '{default: '0};
      else en = '{vd, vd && ld, vd ? ctrl : 16'h0, mread(r1, rw, rdw, res), mread(r2, rw, rdw, res),
                  imm, pc, r1, r2, rdd};
      @(negedge clk);
      drive(ins, vd, ctrl, u1, u2, ld, fl, rw, rdw, res, imm, pc);
      #1 chk($sformatf("rnd%0d stall_D", n), stall_D, haz);
      @(posedge clk);
      #1;
      e = en;
      if (rw && rdw != 0) mregs[rdw] = res;
      if (haz && !fl && mcnt < 3) mcnt++;
      chk($sformatf("rnd%0d valid_E", n), valid_E, e.vld);
      chk($sformatf("rnd%0d isLoad_E", n), isLoad_E, e.ld);
      chk($sformatf("rnd%0d ctrl_E", n), ctrl_E, e.ctrl);
      chk($sformatf("rnd%0d RD1_E", n), RD1_E, e.rd1);
      chk($sformatf("rnd%0d RD2_E", n), RD2_E, e.rd2);
      chk($sformatf("rnd%0d imm_E", n), imm_E, e.imm);
      chk($sformatf("rnd%0d pc_E", n), pc_E, e.pc);
      chk($sformatf("rnd%0d Rs1_E", n), Rs1_E, e.rs1);
      chk($sformatf("rnd%0d Rs2_E", n), Rs2_E, e.rs2);
      chk($sformatf("rnd%0d Rd_E", n), Rd_E, e.rd);
      chk($sformatf("rnd%0d a0", n), a0, mregs[10]);
      chk($sformatf("rnd%0d stall_cnt", n), stall_cnt, mcnt);
    end

    // Saturation: five load-use stalls on a 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(mk(7,0,0), 1, 16'h0001, 0, 0, 1, 0, 0, 0, 0);
      cyc(mk(8,7,0), 1, 16'h0002, 1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("sat%0d stall_D", i), stall_s, 1);
      chk($sformatf("sat%0d stall_cnt", i), stall_cnt, (i + 1 > 3) ? 3 : i + 1);
      cyc(mk(8,7,0), 1, 16'h0002, 1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("sat%0d release", i), stall_s, 0);
    end

    // Asynchronous reset in the middle of a stall
    cyc(mk(1,0,0), 1, 16'h0003, 0, 0, 0, 0, 1, 10, 32'hA5A5A5A5);
    cyc(mk(7,0,0), 1, 16'h0004, 0, 0, 1, 0, 0, 0, 0);
    chk("mid a0 before", a0, 32'hA5A5A5A5);
    @(negedge clk);
    drive(mk(9,7,0), 1, 16'h0005, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    #1 chk("mid stall before", stall_D, 1);
    rst = 1'b0;
    #1;
    chk("mid stall_D", stall_D, 0);   chk("mid valid_E", valid_E, 0);
    chk("mid isLoad_E", isLoad_E, 0); chk("mid ctrl_E", ctrl_E, 0);
    chk("mid Rd_E", Rd_E, 0);         chk("mid RD1_E", RD1_E, 0);
    chk("mid a0", a0, 0);             chk("mid stall_cnt", stall_cnt, 0);
    #1 rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
